// File: rtl/sched_pkg.sv
// Shared types and constants for the core scheduler.
package sched_pkg;

    localparam int unsigned NCORES = 4;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned PC_W   = 16;
    localparam int unsigned PR_W   = 4;
    localparam int unsigned AW_W   = 19;
    localparam int unsigned PCP_W  = 17;
    localparam int unsigned STALL_W = 3;

    typedef enum logic [1:0] {
        SLEEP  = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } core_state_e;

    localparam logic [STALL_W-1:0] STALL_NONE = 3'd0;
    localparam logic [STALL_W-1:0] STALL_RD   = 3'd4;
    localparam logic [STALL_W-1:0] STALL_WR   = 3'd6;

    // pauseResume field offsets
    localparam int unsigned PR_VALID_BIT  = 3;
    localparam int unsigned PR_RESUME_BIT = 2;
    localparam int unsigned PR_TGT_LSB    = 0;

    // pc_out field offsets
    localparam int unsigned AW_VALID_BIT = 18;
    localparam int unsigned AW_TGT_LSB   = 16;
    localparam int unsigned AW_PC_LSB    = 0;

    // One-hot grant to core index
    function automatic logic [1:0] onehot_idx(input logic [3:0] g);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter; pointer moves past each winner.
module rr_arb4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       valid
);

    logic [1:0] ptr_q;
    logic [1:0] ptr_d;
    logic [1:0] idx;

    // Cyclic search for the first requester at or after the pointer
    always_comb begin
        valid = 1'b0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!valid && req[ptr_q + 2'(i)]) begin
                valid = 1'b1;
                idx   = ptr_q + 2'(i);
            end
        end
        gnt   = valid ? (4'b0001 << idx) : 4'b0000;
        ptr_d = valid ? idx + 2'd1 : ptr_q;
    end

    // Pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 2'd0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/core_scheduler.sv
// Arbitrates shared memory ports among four cores and tracks core run state.
module core_scheduler
    import sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ld_req,
    input  logic [59:0] ld_addr,
    input  logic [3:0]  wr_req,
    input  logic [59:0] wr_addr,
    input  logic [63:0] wr_data,
    input  logic [15:0] pr_req,
    input  logic [75:0] aw_req,
    output logic [15:0] mem_raddr,
    output logic        mem_wen,
    output logic [14:0] mem_waddr,
    output logic [15:0] mem_wdata,
    output logic [11:0] stall_num,
    output logic [67:0] pc_passed,
    output logic [7:0]  core_state
);

    core_state_e        state_q [NCORES];
    core_state_e        state_d [NCORES];
    logic [3:0]         run;
    logic [3:0]         ld_elig;
    logic [3:0]         wr_elig;
    logic [3:0]         rd_gnt;
    logic [3:0]         wr_gnt;
    logic               rd_valid;
    logic               wr_valid;
    logic [1:0]         rd_idx;
    logic [1:0]         wr_idx;
    logic [3:0]         aw_hit;
    logic [3:0]         res_hit;
    logic [3:0]         pau_hit;
    logic [PC_W-1:0]    aw_pc [NCORES];
    logic [AW_W-1:0]    aw_w;
    logic [PR_W-1:0]    pr_w;
    logic [1:0]         aw_tgt;
    logic [1:0]         pr_tgt;
    logic [67:0]        pcp_d;

    // Only running cores may compete or issue control requests
    always_comb begin
        run = '0;
        for (int c = 0; c < NCORES; c++) begin
            run[c] = (state_q[c] == RUN);
        end
        ld_elig = ld_req & run;
        wr_elig = wr_req & run;
    end

    rr_arb4 u_rd_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (ld_elig),
        .gnt   (rd_gnt),
        .valid (rd_valid)
    );

    rr_arb4 u_wr_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (wr_elig),
        .gnt   (wr_gnt),
        .valid (wr_valid)
    );

    // Steer the winners onto the memory ports; bit 15 of mem_raddr is the valid flag
    always_comb begin
        rd_idx    = onehot_idx(rd_gnt);
        wr_idx    = onehot_idx(wr_gnt);
        mem_raddr = rd_valid ? {1'b1, ld_addr[ADDR_W*rd_idx +: ADDR_W]} : 16'h0000;
        mem_wen   = wr_valid;
        mem_waddr = wr_valid ? wr_addr[ADDR_W*wr_idx +: ADDR_W] : 15'h0000;
        mem_wdata = wr_valid ? wr_data[DATA_W*wr_idx +: DATA_W] : 16'h0000;
    end

    // Per-core stall: not running, then write loss, then read loss
    always_comb begin
        stall_num = '0;
        for (int c = 0; c < NCORES; c++) begin
            if (!run[c])
                stall_num[STALL_W*c +: STALL_W] = STALL_WR;
            else if (wr_elig[c] && !wr_gnt[c])
                stall_num[STALL_W*c +: STALL_W] = STALL_WR;
            else if (ld_elig[c] && !rd_gnt[c])
                stall_num[STALL_W*c +: STALL_W] = STALL_RD;
            else
                stall_num[STALL_W*c +: STALL_W] = STALL_NONE;
        end
    end

    // Decode awaken / pause / resume per target; lowest awakening requester wins
    always_comb begin
        aw_hit  = '0;
        res_hit = '0;
        pau_hit = '0;
        aw_w    = '0;
        pr_w    = '0;
        aw_tgt  = '0;
        pr_tgt  = '0;
        for (int t = 0; t < NCORES; t++) aw_pc[t] = '0;
        for (int c = 0; c < NCORES; c++) begin
            aw_w   = aw_req[AW_W*c +: AW_W];
            pr_w   = pr_req[PR_W*c +: PR_W];
            aw_tgt = aw_w[AW_TGT_LSB +: 2];
            pr_tgt = pr_w[PR_TGT_LSB +: 2];
            if (run[c] && aw_w[AW_VALID_BIT] && !aw_hit[aw_tgt]) begin
                aw_hit[aw_tgt] = 1'b1;
                aw_pc[aw_tgt]  = aw_w[AW_PC_LSB +: PC_W];
            end
            if (run[c] && pr_w[PR_VALID_BIT]) begin
                if (pr_w[PR_RESUME_BIT]) res_hit[pr_tgt] = 1'b1;
                else                     pau_hit[pr_tgt] = 1'b1;
            end
        end
    end

    // Next run state: awaken over resume over pause
    always_comb begin
        pcp_d = '0;
        for (int t = 0; t < NCORES; t++) begin
            state_d[t] = state_q[t];
            if (aw_hit[t]) begin
                state_d[t] = RUN;
                pcp_d[PCP_W*t +: PCP_W] = {1'b1, aw_pc[t]};
            end else if (res_hit[t]) begin
                if (state_q[t] == PAUSED) state_d[t] = RUN;
            end else if (pau_hit[t]) begin
                if (state_q[t] == RUN) state_d[t] = PAUSED;
            end
        end
    end

    // State and pc_passed registers; core 0 comes out of reset running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCORES; c++) state_q[c] <= (c == 0) ? RUN : SLEEP;
            pc_passed <= '0;
        end else begin
            for (int c = 0; c < NCORES; c++) state_q[c] <= state_d[c];
            pc_passed <= pcp_d;
        end
    end

    // Pack state for observation
    always_comb begin
        core_state = '0;
        for (int c = 0; c < NCORES; c++) core_state[2*c +: 2] = state_q[c];
    end

endmodule
